// File: rtl/pyc_upsizer.sv
// Ready/valid width upsizer: packs RATIO narrow beats into one registered wide word,
// flushing a partial word early when a beat carries in_last.
module pyc_upsizer #(
    parameter  int IN_WIDTH = 8,
    parameter  int RATIO    = 4,
    localparam int CW       = $clog2(RATIO) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [CW-1:0]             out_count,
    output logic                      out_last
);

    localparam int             OUT_W     = IN_WIDTH * RATIO;
    localparam logic [CW-1:0]  LAST_LANE = CW'(RATIO - 1);

    logic [CW-1:0]    fill;
    logic [OUT_W-1:0] word;
    logic             accept;
    logic             complete;

    // Only out_ready reaches in_ready combinationally; in_* never feeds back.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign complete = accept & (in_last | (fill == LAST_LANE));

    generate
        if (RATIO > 1) begin : g_pack
            localparam int ACC_W = IN_WIDTH * (RATIO - 1);

            logic [ACC_W-1:0] acc;

            // Assembly stage: lanes at or above fill stay zero, so the completed
            // word needs no masking beyond dropping the new beat into lane fill.
            always_ff @(posedge clk) begin
                if (rst) begin
                    fill <= '0;
                    acc  <= '0;
                end else if (complete) begin
                    fill <= '0;
                    acc  <= '0;
                end else if (accept) begin
                    acc[fill*IN_WIDTH +: IN_WIDTH] <= in_data;
                    fill                           <= fill + CW'(1);
                end
            end

            always_comb begin
                word                           = '0;
                word[ACC_W-1:0]                = acc;
                word[fill*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end else begin : g_pass
            assign fill = '0;
            assign word = in_data;
        end
    endgenerate

    // Output stage: reload on a completing beat (also while draining), else drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_data  <= word;
            out_count <= fill + CW'(1);
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
